// File: rtl/secded_pkg.sv
// secded_pkg
// Shared types and helpers for the SEC-DED protected counter.
//   BLOCK_W / CHK_W  : data and check bits per protected nibble
//   state_e          : scrubber / counter FSM states
//   decode_t         : flip mask and double-error flag from a syndrome
//   secded_encode()  : extended Hamming (8,4) check bits {p3,p2,p1,p0}
//   secded_decode()  : map {syndrome, overall parity} to a correction
package secded_pkg;

  localparam int BLOCK_W = 4;
  localparam int CHK_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    ENCODE,
    CHECK,
    FIX
  } state_e;

  typedef struct packed {
    logic [CHK_W-1:0]   chkFlip;
    logic [BLOCK_W-1:0] dataFlip;
    logic               dbl;
  } decode_t;

  function automatic logic [CHK_W-1:0] secded_encode(input logic [BLOCK_W-1:0] d);
    logic p0, p1, p2, p3;
    p2 = d[0] ^ d[2] ^ d[3];
    p1 = d[0] ^ d[1] ^ d[3];
    p0 = d[0] ^ d[1] ^ d[2];
    p3 = d[0] ^ d[1] ^ d[2] ^ d[3] ^ p0 ^ p1 ^ p2;
    return {p3, p2, p1, p0};
  endfunction

  // With overall parity odd there is exactly one flipped bit; a zero syndrome
  // means that bit is the overall parity bit itself. Even overall parity with a
  // non-zero syndrome can only come from two flips and is not correctable.
  function automatic decode_t secded_decode(input logic [2:0] syn, input logic ov);
    decode_t r;
    r = '0;
    if (ov) begin
      case (syn)
        3'b111:  r.dataFlip = 4'b0001;
        3'b011:  r.dataFlip = 4'b0010;
        3'b101:  r.dataFlip = 4'b0100;
        3'b110:  r.dataFlip = 4'b1000;
        3'b001:  r.chkFlip  = 4'b0001;
        3'b010:  r.chkFlip  = 4'b0010;
        3'b100:  r.chkFlip  = 4'b0100;
        default: r.chkFlip  = 4'b1000;
      endcase
    end else if (syn != 3'b000) begin
      r.dbl = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/secded_nibble_codec.sv
// secded_nibble_codec
// Combinational codec for one 4-bit protected block.
//   data_i, check_i : stored nibble and its stored check bits {p3,p2,p1,p0}
//   syn_i, ov_i     : previously captured syndrome / overall parity
//   enc_o           : freshly encoded check bits for data_i
//   syn_o, ov_o     : live syndrome and overall parity of the stored block
//   data_fix_o      : data_i with the captured correction applied
//   check_fix_o     : check_i with the captured correction applied
//   single_o        : the captured syndrome calls for a correction
//   double_o        : the captured syndrome indicates a double-bit error
module secded_nibble_codec
  import secded_pkg::*;
(
  input  logic [BLOCK_W-1:0] data_i,
  input  logic [CHK_W-1:0]   check_i,
  input  logic [2:0]         syn_i,
  input  logic               ov_i,
  output logic [CHK_W-1:0]   enc_o,
  output logic [2:0]         syn_o,
  output logic               ov_o,
  output logic [BLOCK_W-1:0] data_fix_o,
  output logic [CHK_W-1:0]   check_fix_o,
  output logic               single_o,
  output logic               double_o
);

  decode_t dec;

  assign enc_o = secded_encode(data_i);
  assign syn_o = check_i[2:0] ^ enc_o[2:0];
  assign ov_o  = ^{check_i, data_i};

  // Correction uses the syndrome captured earlier, not the live one, so the
  // decision made in CHECK is the one applied in FIX.
  assign dec         = secded_decode(syn_i, ov_i);
  assign data_fix_o  = data_i ^ dec.dataFlip;
  assign check_fix_o = check_i ^ dec.chkFlip;
  assign single_o    = |{dec.chkFlip, dec.dataFlip};
  assign double_o    = dec.dbl;

endmodule

// File: rtl/secded_counter_scrub.sv
// secded_counter_scrub
// Up/down counter whose value is stored as SEC-DED protected nibbles, with an
// idle-time scrubber that corrects single-bit upsets and flags double-bit ones.
//   clk_i          : clock, all state on the rising edge
//   rst_ni         : asynchronous active-low reset
//   enable_i       : count one step per cycle
//   up_down_i      : 1 = increment, 0 = decrement
//   load_i         : load load_value_i (wins over everything but reset)
//   load_value_i   : value taken on load
//   scrub_now_i    : request an immediate scrub
//   inj_valid_i    : error-injection strobe (IDLE only)
//   inj_mask_i     : XOR mask applied to {parity, counter}
//   counter_o      : stored counter value
//   parity_o       : stored check bits, block i at [4i+3:4i] = {p3,p2,p1,p0}
//   valid_o        : parity is consistent with the encoded counter
//   corr_pulse_o   : one-cycle pulse after a scrub that corrected something
//   uncorr_o       : sticky double-bit error flag
//   corr_count_o   : saturating count of correcting scrubs
module secded_counter_scrub
  import secded_pkg::*;
#(
  parameter int WIDTH        = 8,   // multiple of 4, at least 4
  parameter int SCRUB_PERIOD = 16,  // at least 2
  parameter int ERRCNT_W     = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic                        up_down_i,
  input  logic                        load_i,
  input  logic [WIDTH-1:0]            load_value_i,
  input  logic                        scrub_now_i,
  input  logic                        inj_valid_i,
  input  logic [WIDTH+WIDTH-1:0]      inj_mask_i,
  output logic [WIDTH-1:0]            counter_o,
  output logic [WIDTH-1:0]            parity_o,
  output logic                        valid_o,
  output logic                        corr_pulse_o,
  output logic                        uncorr_o,
  output logic [ERRCNT_W-1:0]         corr_count_o
);

  localparam int BLOCKS = WIDTH / BLOCK_W;
  localparam int PBITS  = BLOCKS * CHK_W;
  localparam int TMR_W  = $clog2(SCRUB_PERIOD);

  state_e                          state_q, state_d;
  logic [WIDTH-1:0]                counter_q, counter_d;
  logic [PBITS-1:0]                parity_q, parity_d;
  logic                            valid_q, valid_d;
  logic                            corrPulse_q, corrPulse_d;
  logic                            uncorr_q, uncorr_d;
  logic [ERRCNT_W-1:0]             corrCount_q, corrCount_d;
  logic [TMR_W-1:0]                timer_q, timer_d;
  logic [BLOCKS-1:0][2:0]          syn_q, syn_d;
  logic [BLOCKS-1:0]               ov_q, ov_d;

  logic [BLOCKS-1:0][CHK_W-1:0]    encBlk;
  logic [BLOCKS-1:0][2:0]          synNow;
  logic [BLOCKS-1:0]               ovNow;
  logic [BLOCKS-1:0][BLOCK_W-1:0]  dataFix;
  logic [BLOCKS-1:0][CHK_W-1:0]    checkFix;
  logic [BLOCKS-1:0]               singleBlk;
  logic [BLOCKS-1:0]               doubleBlk;

  logic [PBITS-1:0]                loadParity;
  logic [WIDTH-1:0]                countNext;
  logic                            scrubDue;

  for (genvar i = 0; i < BLOCKS; i++) begin : gBlk
    secded_nibble_codec uCodec (
      .data_i      (counter_q[BLOCK_W*i +: BLOCK_W]),
      .check_i     (parity_q[CHK_W*i +: CHK_W]),
      .syn_i       (syn_q[i]),
      .ov_i        (ov_q[i]),
      .enc_o       (encBlk[i]),
      .syn_o       (synNow[i]),
      .ov_o        (ovNow[i]),
      .data_fix_o  (dataFix[i]),
      .check_fix_o (checkFix[i]),
      .single_o    (singleBlk[i]),
      .double_o    (doubleBlk[i])
    );
  end

  // Load bypasses the stored data, so its check bits come straight from the
  // encoder function rather than the per-block codecs.
  always_comb begin
    loadParity = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      loadParity[CHK_W*i +: CHK_W] = secded_encode(load_value_i[BLOCK_W*i +: BLOCK_W]);
    end
  end

  assign countNext = up_down_i ? (counter_q + WIDTH'(1)) : (counter_q - WIDTH'(1));
  assign scrubDue  = scrub_now_i || (timer_q == TMR_W'(SCRUB_PERIOD - 1));

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    parity_d    = parity_q;
    valid_d     = valid_q;
    corrPulse_d = 1'b0;
    uncorr_d    = uncorr_q;
    corrCount_d = corrCount_q;
    timer_d     = '0;
    syn_d       = syn_q;
    ov_d        = ov_q;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          counter_d = countNext;
          valid_d   = 1'b0;
          state_d   = COUNT;
        end else begin
          // Injection deliberately leaves valid set so the scrubber treats
          // the corrupted word as real stored data.
          if (inj_valid_i) begin
            counter_d = counter_q ^ inj_mask_i[WIDTH-1:0];
            parity_d  = parity_q ^ inj_mask_i[WIDTH +: PBITS];
          end
          if (scrubDue) begin
            state_d = CHECK;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end

      COUNT: begin
        if (enable_i) begin
          counter_d = countNext;
          valid_d   = 1'b0;
        end else begin
          state_d = ENCODE;
        end
      end

      ENCODE: begin
        parity_d = encBlk;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end

      CHECK: begin
        // A count request abandons the scrub; nothing captured here is used.
        if (enable_i) begin
          counter_d = countNext;
          valid_d   = 1'b0;
          state_d   = COUNT;
        end else begin
          syn_d   = synNow;
          ov_d    = ovNow;
          state_d = FIX;
        end
      end

      FIX: begin
        counter_d = dataFix;
        parity_d  = checkFix;
        if (|singleBlk) begin
          corrPulse_d = 1'b1;
          if (corrCount_q != '1) begin
            corrCount_d = corrCount_q + ERRCNT_W'(1);
          end
        end
        if (|doubleBlk) begin
          uncorr_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Load discards whatever the FSM was doing, including a pending fix.
    if (load_i) begin
      counter_d   = load_value_i;
      parity_d    = loadParity;
      valid_d     = 1'b1;
      uncorr_d    = 1'b0;
      corrPulse_d = 1'b0;
      corrCount_d = corrCount_q;
      timer_d     = '0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      parity_q    <= '0;
      valid_q     <= 1'b1;
      corrPulse_q <= 1'b0;
      uncorr_q    <= 1'b0;
      corrCount_q <= '0;
      timer_q     <= '0;
      syn_q       <= '0;
      ov_q        <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      parity_q    <= parity_d;
      valid_q     <= valid_d;
      corrPulse_q <= corrPulse_d;
      uncorr_q    <= uncorr_d;
      corrCount_q <= corrCount_d;
      timer_q     <= timer_d;
      syn_q       <= syn_d;
      ov_q        <= ov_d;
    end
  end

  assign counter_o    = counter_q;
  assign parity_o     = parity_q;
  assign valid_o      = valid_q;
  assign corr_pulse_o = corrPulse_q;
  assign uncorr_o     = uncorr_q;
  assign corr_count_o = corrCount_q;

endmodule

// File: doc/secded_counter_scrub.md
# secded_counter_scrub

Parametrised, SEC-DED-protected up/down counter with a background scrubber. The counter value is split into 4-bit blocks; each block carries an extended Hamming (8,4) codeword: three check bits plus an overall parity bit. An idle-time FSM periodically re-checks storage, corrects single-bit upsets per block, and flags double-bit upsets. It is the next generation of the counter/parity/syndrome pair and replaces it in the counter datapath.

## Interface
- WIDTH, 8, counter width; must be a multiple of 4, minimum 4
- BLOCKS, WIDTH/4, number of 4-bit protected blocks
- PBITS, BLOCKS*4, stored check bits (4 per block)
- SCRUB_PERIOD, 16, idle cycles between automatic scrubs; minimum 2
- ERRCNT_W, 8, width of the corrected-error counter
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  count request, one step per cycle
- up_down  in  1  1 = increment, 0 = decrement
- load  in  1  load load_value; highest priority after reset
- load_value  in  WIDTH  value taken by load
- scrub_now  in  1  request an immediate scrub
- inj_valid  in  1  error-injection strobe, for test
- inj_mask  in  WIDTH+PBITS  XOR mask applied to {parity, counter}
- counter  out  WIDTH  stored counter value
- parity  out  PBITS  stored check bits; block i occupies [4i+3:4i] = {p3,p2,p1,p0}
- valid  out  1  parity is consistent with the encoded counter
- corr_pulse  out  1  one-cycle pulse when at least one block was corrected
- uncorr  out  1  sticky flag for a double-bit error in any block
- corr_count  out  ERRCNT_W  saturating count of scrubs that performed a correction

## Operation
- Encode per block, with d = counter[4i+3:4i]:
  - p2 = d0^d2^d3
  - p1 = d0^d1^d3
  - p0 = d0^d1^d2
  - p3 = d0^d1^d2^d3^p0^p1^p2
- Syndrome per block: s = {p2,p1,p0}stored ^ recomputed; ov = XOR of all 8 stored bits.
  - s=0, ov=0: clean.
  - s≠0, ov=1: single error. 111 flips d0, 011 flips d1, 101 flips d2, 110 flips d3, 001/010/100 flip p0/p1/p2.
  - s=0, ov=1: flip p3.
  - s≠0, ov=0: double error. Set uncorr and leave the block unchanged.
- FSM states: IDLE, COUNT, ENCODE, CHECK, FIX.
  - IDLE: enable → COUNT; scrub_now or scrub timer reaching SCRUB_PERIOD-1 → CHECK.
  - COUNT: counter ±1 each cycle with enable high, wrapping modulo 2^WIDTH; valid=0. Enable low → ENCODE.
  - ENCODE: write parity = encode(counter); valid=1; → IDLE.
  - CHECK: register the syndromes; → FIX. If enable is high, abort to COUNT with no write.
  - FIX: apply corrections; corr_count += 1 if any block was corrected, saturating at all-ones; → IDLE. Enable in FIX is deferred one cycle.
- load, in any state: counter = load_value, parity = encode(load_value), valid=1, uncorr cleared, scrub timer cleared, state → IDLE. load wins over enable.
- inj_valid is honoured only in IDLE without load: {parity,counter} ^= inj_mask. valid stays 1 so the scrubber sees the error.
- The scrub timer runs only in IDLE and clears on leaving IDLE.

## Timing
- Reset values: counter=0, parity=0, valid=1, corr_pulse=0, uncorr=0, corr_count=0, state=IDLE, timer=0.
- Count: enable sampled high at edge k → counter changes at edge k.
- ENCODE occupies one cycle after enable falls; parity and valid are updated at the following edge.
- scrub_now at edge k: CHECK cycle k+1, FIX cycle k+2. The corrected counter/parity and corr_pulse=1 are visible after edge k+3; corr_pulse lasts one cycle.
- Automatic scrub: CHECK is entered SCRUB_PERIOD cycles after entry to IDLE.
- Reset asserted mid-CHECK/FIX: all state returns to reset values immediately and no partial correction is retained.

## Structure
- Package secded_pkg:
  - state enum
  - BLOCK_W=4 and CHK_W=4
  - functions secded_encode(d) and secded_decode(syn, ov) returning flip mask and double flag
- Sub-module secded_nibble_codec: combinational encode, syndrome and correct for one block; instantiated BLOCKS times via generate.
- Top holds the FSM, counter/parity registers, scrub timer and statistics.

## Test plan
- Reset release → counter=0x00, parity=0x00, valid=1, uncorr=0, corr_count=0.
- enable high 5 cycles, up_down=1, then low → counter=0x05; after ENCODE parity=0x0A, valid=1.
- From 0x05 idle, inj_mask flips counter bit 2 → counter=0x01; scrub_now → counter=0x05 3 cycles later, corr_pulse one cycle, corr_count=1.
- From 0x05, inject a flip of counter bits 0 and 1 (block 0) → scrub leaves counter=0x06, uncorr=1, corr_count unchanged; then load 0x05 → uncorr=0.
- From 0x00, up_down=0, enable 1 cycle → counter=0xFF (wrap). load=0x3C with enable=1 → counter=0x3C, state IDLE, valid=1.
- Idle with no requests → CHECK starts 16 cycles after IDLE entry. enable raised in CHECK → COUNT, no correction written. Reset asserted in FIX → all outputs return to reset values.
